// File: rtl/memory_module.sv
// Simple dual-port register memory: one write port, one registered read port.
// Asynchronous active-low reset clears every word and the read register at once.
module memory_module #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int MEMORY_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] read_address,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    logic [MEMORY_DEPTH-1:0][DATA_WIDTH-1:0] mem_flat;
    logic [IDX_W-1:0]                        rd_idx;
    logic                                    rd_in_range;
    logic [DATA_WIDTH-1:0]                   data_out_d;
    logic [DATA_WIDTH-1:0]                   data_out_q;

    // Words live in flops rather than block RAM so that reset can clear them all instantly.
    for (genvar gi = 0; gi < MEMORY_DEPTH; gi++) begin : g_word
        logic [DATA_WIDTH-1:0] word_d;
        logic [DATA_WIDTH-1:0] word_q;

        // Out-of-range write addresses match no word, so they are dropped here.
        always_comb begin
            word_d = word_q;
            if (we && (write_address == ADDR_WIDTH'(gi))) begin
                word_d = data_in;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end

        assign mem_flat[gi] = word_q;
    end

    if (MEMORY_DEPTH >= (2 ** ADDR_WIDTH)) begin : g_full_range
        assign rd_in_range = 1'b1;
    end else begin : g_part_range
        assign rd_in_range = (read_address < ADDR_WIDTH'(MEMORY_DEPTH));
    end

    assign rd_idx = read_address[IDX_W-1:0];

    // Reads see the pre-edge contents, which gives old-data on a same-address collision.
    always_comb begin
        data_out_d = data_out_q;
        if (re) begin
            data_out_d = rd_in_range ? mem_flat[rd_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_memory_module.sv
// Scoreboard bench for memory_module: a full-range instance plus a 16-word
// instance that shares the stimulus and exercises out-of-range addressing.
module tb_memory_module;

    logic       clk;
    logic       rstn;
    logic [7:0] write_address;
    logic [7:0] data_in;
    logic       we;
    logic [7:0] read_address;
    logic       re;
    logic [7:0] dout_a;
    logic [7:0] dout_b;

    typedef struct {
        string      name;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_a [256];
    logic [7:0] model_b [16];
    logic [7:0] out_a;
    logic [7:0] out_b;
    int         n_checks;
    int         n_fail;

    memory_module #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEMORY_DEPTH(256)) u_dut (
        .clk(clk), .rstn(rstn), .write_address(write_address), .data_in(data_in),
        .we(we), .read_address(read_address), .re(re), .data_out(dout_a)
    );

    memory_module #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEMORY_DEPTH(16)) u_small (
        .clk(clk), .rstn(rstn), .write_address(write_address), .data_in(data_in),
        .we(we), .read_address(read_address), .re(re), .data_out(dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_a[i] = 8'h00;
        for (int i = 0; i < 16; i++) model_b[i] = 8'h00;
        out_a = 8'h00;
        out_b = 8'h00;
    endtask

    // One clock of stimulus: push the expected data_out, clock, then pop and compare.
    task automatic step(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                        input logic r, input logic [7:0] ra, input string name);
        exp_t e;
        we = w; write_address = wa; data_in = wd; re = r; read_address = ra;
        e.name = name;
        if (!rstn) begin
            e.exp_a = 8'h00;
            e.exp_b = 8'h00;
        end else begin
            e.exp_a = r ? model_a[ra] : out_a;
            e.exp_b = r ? ((ra < 8'd16) ? model_b[ra[3:0]] : 8'h00) : out_b;
            if (w) begin
                model_a[wa] = wd;
                if (wa < 8'd16) model_b[wa[3:0]] = wd;
            end
        end
        out_a = e.exp_a;
        out_b = e.exp_b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks += 2;
        if (dout_a !== e.exp_a) begin
            n_fail++;
            $display("FAIL %s (depth256): data_out=%h expected=%h", e.name, dout_a, e.exp_a);
        end
        if (dout_b !== e.exp_b) begin
            n_fail++;
            $display("FAIL %s (depth16): data_out=%h expected=%h", e.name, dout_b, e.exp_b);
        end
        $display("txn %-14s we=%b wa=%h di=%h re=%b ra=%h -> a=%h b=%h", e.name, w, wa, wd, r, ra, dout_a, dout_b);
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "reset_hold");
        step(1'b1, 8'h01, 8'h5A, 1'b1, 8'h01, "reset_wr_ign");
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 8'(i), "reset_read0");
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 8'(8'hA0 + i), 1'b0, 8'h00, "write_a0");
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 8'(i), "read_a0");
        n_checks++;
        if (dout_a !== 8'hA4) begin
            n_fail++;
            $display("FAIL read_last: data_out=%h expected=a4", dout_a);
        end
    endtask

    task automatic test_hold();
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "hold");
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "hold");
        n_checks++;
        if (dout_a !== 8'hA4) begin
            n_fail++;
            $display("FAIL hold_const: data_out=%h expected=a4", dout_a);
        end
        step(1'b0, 8'h10, 8'hFF, 1'b0, 8'h00, "we0_write");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, "we0_read");
    endtask

    task automatic test_dual_port();
        step(1'b1, 8'h20, 8'h55, 1'b1, 8'h00, "dual_port");
        n_checks++;
        if (dout_a !== 8'hA0) begin
            n_fail++;
            $display("FAIL dual_const: data_out=%h expected=a0", dout_a);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h20, "dual_next");
    endtask

    task automatic test_collision();
        step(1'b1, 8'h04, 8'h77, 1'b1, 8'h04, "collide_old");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h04, "collide_new");
        step(1'b1, 8'h40, 8'h3C, 1'b1, 8'h40, "collide_old2");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h40, "collide_new2");
    endtask

    task automatic test_boundary();
        step(1'b1, 8'hFF, 8'hBB, 1'b0, 8'h00, "top_write");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, "top_read");
        step(1'b1, 8'h0F, 8'hEE, 1'b0, 8'h00, "small_top_wr");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h0F, "small_top_rd");
        step(1'b1, 8'h00, 8'hCC, 1'b0, 8'h00, "overwrite");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "overwrite_rd");
        step(1'b1, 8'h10, 8'h99, 1'b0, 8'h00, "oor_write");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, "oor_read");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "no_wrap");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h50 + i), 8'($urandom_range(1, 255)), 1'b1,
                 8'(8'h50 + i - 1), "b2b");
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h57, "b2b_last");
    endtask

    task automatic test_async_reset();
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "pre_reset");
        we = 1'b1; write_address = 8'h30; data_in = 8'hDD; re = 1'b1; read_address = 8'h00;
        #2;
        rstn = 1'b0;
        #1;
        clear_model();
        n_checks += 2;
        if (dout_a !== 8'h00) begin
            n_fail++;
            $display("FAIL async_clear (depth256): data_out=%h expected=00", dout_a);
        end
        if (dout_b !== 8'h00) begin
            n_fail++;
            $display("FAIL async_clear (depth16): data_out=%h expected=00", dout_b);
        end
        step(1'b1, 8'h30, 8'hDD, 1'b1, 8'h00, "in_reset");
        rstn = 1'b1;
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h30, "lost_write");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "cleared_00");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h0F, "cleared_0f");
        step(1'b1, 8'h31, 8'h42, 1'b0, 8'h00, "post_write");
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h31, "post_read");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn = 1'b0; we = 1'b0; re = 1'b0;
        write_address = 8'h00; read_address = 8'h00; data_in = 8'h00;
        clear_model();
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_hold();
        test_dual_port();
        test_collision();
        test_boundary();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
